// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: owns the PC, issues sequential reads, queues results.
// Optional `FETCH_PREDECODE_EN adds JAL predecode and redirection of the fetch PC.
module inst_fetch_queue #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INST_WIDTH  = 32,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  cdb_valid,
    input  logic [ADDR_WIDTH-1:0] cdb_data,
    input  logic                  rd_mem_done,
    input  logic [INST_WIDTH-1:0] rd_mem_data,
    output logic                  rd_mem_valid,
    output logic [ADDR_WIDTH-1:0] rd_mem_addr,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_pred_taken
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t state;
    state_t state_n;

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  valid_n;
    logic [ADDR_WIDTH-1:0] next_pc;

    logic [INST_WIDTH-1:0] q_data [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_n;

    logic push;
    logic pop;
    logic space;

`ifdef FETCH_PREDECODE_EN
    logic        q_pred [QUEUE_DEPTH];
    logic        pred;
    logic [20:0] jal_imm;

    always_comb begin
        jal_imm = {rd_mem_data[31], rd_mem_data[19:12],
                   rd_mem_data[20], rd_mem_data[30:21], 1'b0};
        pred    = (rd_mem_data[6:0] == 7'b1101111);
        if (pred)
            next_pc = pc + {{(ADDR_WIDTH-21){jal_imm[20]}}, jal_imm};
        else
            next_pc = pc + PC_STEP;
    end
`else
    assign next_pc = pc + PC_STEP;
`endif

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign push       = (state == WAIT) && rd_mem_done && !cdb_valid;

    // Occupancy after this cycle's push/pop; a redirect empties the queue.
    always_comb begin
        count_n = count;
        if (cdb_valid)
            count_n = '0;
        else
            count_n = count + CNT_W'(push) - CNT_W'(pop);
    end

    // Every issue point has no read outstanding, so only count_n matters.
    assign space = (count_n < DEPTH_C);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        valid_n = rd_mem_valid;
        addr_n  = rd_mem_addr;
        if (cdb_valid) begin
            pc_n = cdb_data;
            unique case (state)
                IDLE: begin
                    state_n = WAIT;
                    valid_n = 1'b1;
                    addr_n  = cdb_data;
                end
                WAIT, DISCARD: begin
                    if (rd_mem_done) begin
                        state_n = WAIT;
                        valid_n = 1'b1;
                        addr_n  = cdb_data;
                    end else begin
                        state_n = DISCARD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    if (space) begin
                        state_n = WAIT;
                        valid_n = 1'b1;
                        addr_n  = pc;
                    end
                end
                WAIT: begin
                    if (rd_mem_done) begin
                        pc_n = next_pc;
                        if (space) begin
                            addr_n = next_pc;
                        end else begin
                            state_n = IDLE;
                            valid_n = 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (rd_mem_done) begin
                        if (space) begin
                            state_n = WAIT;
                            valid_n = 1'b1;
                            addr_n  = pc;
                        end else begin
                            state_n = IDLE;
                            valid_n = 1'b0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            rd_mem_valid <= 1'b0;
            rd_mem_addr  <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
        end else if (rdy) begin
            state        <= state_n;
            pc           <= pc_n;
            rd_mem_valid <= valid_n;
            rd_mem_addr  <= addr_n;
            count        <= count_n;
            if (cdb_valid) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push)
                    tail <= tail + PTR_W'(1);
                if (pop)
                    head <= head + PTR_W'(1);
            end
        end
    end

    // Payload storage needs no reset: the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (rdy && push) begin
            q_data[tail] <= rd_mem_data;
            q_pc[tail]   <= pc;
`ifdef FETCH_PREDECODE_EN
            q_pred[tail] <= pred;
`endif
        end
    end

    assign inst_data = inst_valid ? q_data[head] : '0;
    assign inst_pc   = inst_valid ? q_pc[head] : '0;

`ifdef FETCH_PREDECODE_EN
    assign inst_pred_taken = inst_valid ? q_pred[head] : 1'b0;
`else
    assign inst_pred_taken = 1'b0;
`endif

endmodule
